// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (IF/DT/EX/MA/WB) with memory-latency stretching
module mc_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic [1:0] ExtOp,
  output logic [3:0] ALUOp,
  output logic [2:0] nPCOp,
  output logic       Illegal,
  output logic [2:0] State
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_DT = 3'd1, S_EX = 3'd2, S_MA = 3'd3, S_WB = 3'd4} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic is_r, addu, subu, jr, nop, ori, addiu, lw, sw, lui, beq, j, jal, legal, last;
  logic in_if, in_dt, in_ex, in_ma, in_wb;
  assign is_r  = Op == 6'h00;
  assign addu  = is_r && Func == 6'h21;
  assign subu  = is_r && Func == 6'h23;
  assign jr    = is_r && Func == 6'h08;
  assign nop   = is_r && Func == 6'h00;
  assign ori   = Op == 6'h0d;
  assign addiu = Op == 6'h09;
  assign lw    = Op == 6'h23;
  assign sw    = Op == 6'h2b;
  assign lui   = Op == 6'h0f;
  assign beq   = Op == 6'h04;
  assign j     = Op == 6'h02;
  assign jal   = Op == 6'h03;
  assign legal = addu | subu | jr | nop | ori | addiu | lw | sw | lui | beq | j | jal;
  assign last  = cnt_q == CNT_W'(MEM_LAT - 1);
  assign in_if = state_q == S_IF;
  assign in_dt = state_q == S_DT;
  assign in_ex = state_q == S_EX;
  assign in_ma = state_q == S_MA;
  assign in_wb = state_q == S_WB;
  assign RegDst   = jal ? 2'b10 : (addu | subu) ? 2'b01 : 2'b00;
  assign ALUSrc   = ori | addiu | lw | sw | lui;
  assign MemtoReg = jal ? 2'b10 : lw ? 2'b01 : 2'b00;
  assign ExtOp    = ori ? 2'b01 : lui ? 2'b10 : 2'b00;
  assign ALUOp    = ori ? 4'b0010 : (subu | beq) ? 4'b0001 : 4'b0000;
  assign nPCOp    = (in_ex && beq) ? 3'b001 : (in_dt && (j | jal)) ? 3'b010 : (in_dt && jr) ? 3'b011 : 3'b000;
  // Write enables are gated by reset so an aborted instruction never commits anything.
  assign PCWr     = !reset && ((in_if && last) || (in_dt && (j | jal | jr)) || (in_ex && beq && Zero));
  assign IRWr     = !reset && in_if && last;
  assign RegWrite = !reset && ((in_dt && jal) || in_wb);
  assign MemWrite = !reset && in_ma && sw && last;
  assign Illegal  = !reset && in_dt && !legal;
  assign State    = state_q;
  // State sequencing and the latency counter shared by IF and MA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q <= '0;
    end else begin
      cnt_q <= '0;
      case (state_q)
        S_IF: begin
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          state_q <= last ? S_DT : S_IF;
        end
        S_DT: state_q <= (j | jal | jr | nop | !legal) ? S_IF : S_EX;
        S_EX: state_q <= beq ? S_IF : (lw | sw) ? S_MA : S_WB;
        S_MA: begin
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          state_q <= last ? (lw ? S_WB : S_IF) : S_MA;
        end
        S_WB: state_q <= S_IF;
        default: state_q <= S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl at memory latencies 1, 2 and 3
module tb_mc_ctrl;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_JR = 6'h08;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [1:3];
  logic [5:0] op, func;
  logic zero;
  logic pcwr [1:3], irwr [1:3], rw [1:3], mw [1:3], alusrc [1:3], ill [1:3];
  logic [1:0] regdst [1:3], m2r [1:3], extop [1:3];
  logic [3:0] aluop [1:3];
  logic [2:0] npc [1:3], st [1:3];
  for (genvar g = 1; g <= 3; g++) begin : u
    mc_ctrl #(.MEM_LAT(g), .CNT_W(4)) dut (
      .clk(clk), .reset(rst[g]), .Op(op), .Func(func), .Zero(zero),
      .PCWr(pcwr[g]), .IRWr(irwr[g]), .RegWrite(rw[g]), .MemWrite(mw[g]),
      .RegDst(regdst[g]), .ALUSrc(alusrc[g]), .MemtoReg(m2r[g]), .ExtOp(extop[g]),
      .ALUOp(aluop[g]), .nPCOp(npc[g]), .Illegal(ill[g]), .State(st[g])
    );
  end
  typedef struct {
    string tag;
    logic [10:0] ctl;
    logic [10:0] dec;
  } item_t;
  item_t q [$];
  int errors = 0, checks = 0, sel = 1;
  function automatic logic [10:0] ctl_of(input int s);
    return {st[s], pcwr[s], irwr[s], rw[s], mw[s], ill[s], npc[s]};
  endfunction
  function automatic logic [10:0] dec_of(input int s);
    return {regdst[s], alusrc[s], m2r[s], extop[s], aluop[s]};
  endfunction
  function automatic logic [10:0] dec_exp(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_R && f == F_ADDU) return {2'b01, 1'b0, 2'b00, 2'b00, 4'b0000};
    if (o == OP_R && f == F_SUBU) return {2'b01, 1'b0, 2'b00, 2'b00, 4'b0001};
    if (o == OP_ORI)   return {2'b00, 1'b1, 2'b00, 2'b01, 4'b0010};
    if (o == OP_ADDIU) return {2'b00, 1'b1, 2'b00, 2'b00, 4'b0000};
    if (o == OP_LW)    return {2'b00, 1'b1, 2'b01, 2'b00, 4'b0000};
    if (o == OP_SW)    return {2'b00, 1'b1, 2'b00, 2'b00, 4'b0000};
    if (o == OP_LUI)   return {2'b00, 1'b1, 2'b00, 2'b10, 4'b0000};
    if (o == OP_BEQ)   return {2'b00, 1'b0, 2'b00, 2'b00, 4'b0001};
    if (o == OP_JAL)   return {2'b10, 1'b0, 2'b10, 2'b00, 4'b0000};
    return 11'd0;
  endfunction
  task automatic push(input string tag, input logic [2:0] s, input logic pc, input logic ir,
                      input logic r, input logic m, input logic il, input logic [2:0] n);
    item_t it;
    it.tag = tag;
    it.ctl = {s, pc, ir, r, m, il, n};
    it.dec = dec_exp(op, func);
    q.push_back(it);
  endtask
  task automatic drain();
    item_t it;
    while (q.size() > 0) begin
      #1;
      it = q.pop_front();
      checks++;
      assert (ctl_of(sel) === it.ctl) else begin
        errors++;
        $error("FAIL %s ctl(st,pc,ir,rw,mw,ill,npc) got %b want %b", it.tag, ctl_of(sel), it.ctl);
      end
      checks++;
      assert (dec_of(sel) === it.dec) else begin
        errors++;
        $error("FAIL %s dec(rd,src,m2r,ext,alu) got %b want %b", it.tag, dec_of(sel), it.dec);
      end
      @(negedge clk);
    end
  endtask
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z, input int l);
    logic r, jj, jl, jrr, np, bq, ld, st_w, lg;
    op = o;
    func = f;
    zero = z;
    r = o == OP_R;
    jj = o == OP_J;
    jl = o == OP_JAL;
    jrr = r && f == F_JR;
    np = r && f == 6'h00;
    bq = o == OP_BEQ;
    ld = o == OP_LW;
    st_w = o == OP_SW;
    lg = (r && (f == F_ADDU || f == F_SUBU || jrr || np)) || jj || jl || bq || ld || st_w ||
         o == OP_ORI || o == OP_ADDIU || o == OP_LUI;
    for (int c = 0; c < l; c++) push(tag, 3'd0, c == l - 1, c == l - 1, 1'b0, 1'b0, 1'b0, 3'd0);
    push(tag, 3'd1, jj | jl | jrr, 1'b0, jl, 1'b0, !lg, (jj | jl) ? 3'd2 : jrr ? 3'd3 : 3'd0);
    if (!(jj | jl | jrr | np | !lg)) begin
      push(tag, 3'd2, bq & z, 1'b0, 1'b0, 1'b0, 1'b0, bq ? 3'd1 : 3'd0);
      if (ld | st_w)
        for (int c = 0; c < l; c++) push(tag, 3'd3, 1'b0, 1'b0, 1'b0, st_w && c == l - 1, 1'b0, 3'd0);
      if (!bq && !st_w) push(tag, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    end
    drain();
  endtask
  initial begin
    rst[1] = 1'b1;
    rst[2] = 1'b1;
    rst[3] = 1'b1;
    op = OP_R;
    func = F_ADDU;
    zero = 1'b0;
    @(negedge clk);
    sel = 1;
    repeat (3) push("reset1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    drain();
    rst[1] = 1'b0;
    run("addu", OP_R, F_ADDU, 1'b0, 1);
    run("subu", OP_R, F_SUBU, 1'b0, 1);
    run("ori", OP_ORI, 6'h15, 1'b0, 1);
    run("addiu", OP_ADDIU, 6'h00, 1'b0, 1);
    run("lui", OP_LUI, 6'h3c, 1'b0, 1);
    run("beq_z1", OP_BEQ, 6'h00, 1'b1, 1);
    run("beq_z0", OP_BEQ, 6'h00, 1'b0, 1);
    run("j", OP_J, 6'h11, 1'b0, 1);
    run("jal", OP_JAL, 6'h00, 1'b0, 1);
    run("jr", OP_R, F_JR, 1'b0, 1);
    run("nop", OP_R, 6'h00, 1'b0, 1);
    run("ill_op", 6'h3f, 6'h00, 1'b0, 1);
    run("ill_func", OP_R, 6'h2a, 1'b0, 1);
    run("lw1", OP_LW, 6'h00, 1'b0, 1);
    run("sw1", OP_SW, 6'h00, 1'b0, 1);
    sel = 3;
    push("reset3", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    drain();
    rst[3] = 1'b0;
    run("lw3", OP_LW, 6'h00, 1'b0, 3);
    run("beq3", OP_BEQ, 6'h00, 1'b1, 3);
    sel = 2;
    push("reset2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    drain();
    rst[2] = 1'b0;
    run("sw2", OP_SW, 6'h00, 1'b0, 2);
    op = OP_SW;
    func = 6'h00;
    push("abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    push("abort", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    push("abort", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    push("abort", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    push("abort", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    drain();
    rst[2] = 1'b1;
    push("abort_ma", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    drain();
    rst[2] = 1'b0;
    run("after_abort", OP_R, F_ADDU, 1'b0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
